// File: rtl/tmr_voter_monitor.sv
// ----------------------------------------------------------------------------
// tmr_voter_monitor
//   Triple-modular-redundancy voter with per-replica fault tracking.
//   Three WIDTH-bit replica buses are voted bitwise. Per replica it tracks a
//   consecutive-mismatch streak (which masks the replica from voting once it
//   reaches FAULT_THRESH), a saturating disagreement counter and a sticky
//   mismatch flag. Status and counters are reachable over a simple valid/ready
//   register port.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   rep_a_i/rep_b_i/rep_c_i   replica buses 0..2
//   voted_o                   voted bus (registered when REG_OUT=1)
//   mismatch_o[2:0]           replica disagrees with the vote this cycle
//   faulty_o[2:0]             replica masked from voting
//   double_fault_o            sticky: healthy pair disagreed, or a second
//                             replica hit the threshold
//   valid_i/we_i/addr_i/wdata_i  register request (held until ready_o)
//   ready_o/rdata_o           one-cycle acknowledge and read data
//
// Register map
//   0 STATUS {25'b0, double_fault, faulty[2:0], sticky_mm[2:0]}; write is W1C
//   1..3     disagreement counter of replica 0..2; any write clears it
// ----------------------------------------------------------------------------
module tmr_voter_monitor #(
  parameter int WIDTH        = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int FAULT_THRESH = 8,
  parameter bit REG_OUT      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rep_a_i,
  input  logic [WIDTH-1:0] rep_b_i,
  input  logic [WIDTH-1:0] rep_c_i,
  output logic [WIDTH-1:0] voted_o,
  output logic [2:0]       mismatch_o,
  output logic [2:0]       faulty_o,
  output logic             double_fault_o,
  input  logic             valid_i,
  input  logic             we_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic             ready_o,
  output logic [31:0]      rdata_o
);

  localparam int                  SW         = $clog2(FAULT_THRESH + 1);
  localparam logic [SW-1:0]        STREAK_MAX = SW'(FAULT_THRESH);
  localparam logic [SW-1:0]        STREAK_HIT = SW'(FAULT_THRESH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  logic [WIDTH-1:0] rep [3];
  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] vote;
  logic [2:0]       mm;
  logic             pair_dis;

  logic [2:0]           faulty_q, faulty_d;
  logic [2:0]           sticky_q, sticky_d;
  logic                 df_q, df_d;
  logic [SW-1:0]        streak_q [3];
  logic [SW-1:0]        streak_d [3];
  logic [CNT_WIDTH-1:0] cnt_q [3];
  logic [CNT_WIDTH-1:0] cnt_d [3];
  logic                 ready_q, ready_d;
  logic [31:0]          rdata_q, rdata_d;

  logic       accept;
  logic       wr_status;
  logic [2:0] clr_sticky, clr_faulty;
  logic       clr_df;
  logic [2:0] hit, hit_lo, faulty_set;
  logic       df_set;

  // Only the W1C fields of a STATUS write carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i[31:7];

  assign rep[0] = rep_a_i;
  assign rep[1] = rep_b_i;
  assign rep[2] = rep_c_i;
  assign maj    = (rep_a_i & rep_b_i) | (rep_b_i & rep_c_i) | (rep_a_i & rep_c_i);

  // Vote. With one replica masked, the lowest-index healthy replica is the
  // output whether or not the pair agrees, so only the mismatch flags differ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    vote     = maj;
    mm       = '0;
    pair_dis = 1'b0;
    case (faulty_q)
      3'b001: begin
        vote  = rep[1];
        mm[1] = |(rep[1] ^ rep[2]);
        mm[2] = mm[1];
      end
      3'b010: begin
        vote  = rep[0];
        mm[0] = |(rep[0] ^ rep[2]);
        mm[2] = mm[0];
      end
      3'b100: begin
        vote  = rep[0];
        mm[0] = |(rep[0] ^ rep[1]);
        mm[1] = mm[0];
      end
      default: begin
        for (int i = 0; i < 3; i++) mm[i] = |(rep[i] ^ maj);
      end
    endcase
    pair_dis = (faulty_q != 3'b000) && (mm != 3'b000);
  end

  // Register-port decode; a clear always overrides a same-cycle set.
  assign accept     = valid_i & ~ready_q;
  assign wr_status  = accept & we_i & (addr_i == 2'd0);
  assign clr_sticky = wr_status ? wdata_i[2:0] : 3'b000;
  assign clr_faulty = wr_status ? wdata_i[5:3] : 3'b000;
  assign clr_df     = wr_status & wdata_i[6];

  // A replica hits the threshold on the mismatch that takes its streak to
  // FAULT_THRESH. Only one replica may ever be masked; any further hit, or a
  // simultaneous multi-hit, is reported as a double fault instead.
  always_comb begin
    for (int i = 0; i < 3; i++) hit[i] = mm[i] && (streak_q[i] == STREAK_HIT);
  end
  assign hit_lo     = hit & (~hit + 3'd1);
  assign faulty_set = (faulty_q == 3'b000) ? hit_lo : 3'b000;
  assign df_set     = pair_dis | ((hit != 3'b000) && (faulty_q != 3'b000)) | (hit != hit_lo);

  always_comb begin
    faulty_d = (faulty_q | faulty_set) & ~clr_faulty;
    sticky_d = (sticky_q | mm) & ~clr_sticky;
    df_d     = (df_q | df_set) & ~clr_df;
    for (int i = 0; i < 3; i++) begin
      if (clr_faulty[i] || !mm[i])        streak_d[i] = '0;
      else if (streak_q[i] == STREAK_MAX) streak_d[i] = STREAK_MAX;
      else                                streak_d[i] = streak_q[i] + SW'(1);

      if (accept && we_i && (addr_i == 2'(i + 1))) cnt_d[i] = '0;
      else if (mm[i] && (cnt_q[i] != CNT_MAX))     cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      else                                         cnt_d[i] = cnt_q[i];
    end

    ready_d = accept;
    rdata_d = '0;
    if (accept && !we_i) begin
      case (addr_i)
        2'd0:    rdata_d = {25'b0, df_q, faulty_q, sticky_q};
        2'd1:    rdata_d = 32'(cnt_q[0]);
        2'd2:    rdata_d = 32'(cnt_q[1]);
        default: rdata_d = 32'(cnt_q[2]);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      faulty_q <= '0;
      sticky_q <= '0;
      df_q     <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      // NOTE: the streak/counter arrays are plain flops, so every element is
      // cleared on reset; they must never be mapped onto a RAM.
      for (int i = 0; i < 3; i++) begin
        streak_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, regardless of statement order.
      faulty_q <= faulty_d;
      sticky_q <= sticky_d;
      df_q     <= df_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < 3; i++) begin
        streak_q[i] <= streak_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  generate
    if (REG_OUT) begin : g_voted_reg
      logic [WIDTH-1:0] voted_q;
      always_ff @(posedge clk) begin
        if (rst) voted_q <= '0;
        else     voted_q <= vote;
      end
      assign voted_o = voted_q;
    end else begin : g_voted_comb
      assign voted_o = vote;
    end
  endgenerate

  // Reset withdraws an in-flight acknowledge in the same cycle it is raised.
  assign ready_o        = ready_q & ~rst;
  assign rdata_o        = rdata_q;
  assign mismatch_o     = mm;
  assign faulty_o       = faulty_q;
  assign double_fault_o = df_q;

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// ----------------------------------------------------------------------------
// tb_tmr_voter_monitor
//   Scoreboard bench. The stimulus process drives one cycle at a time, runs a
//   behavioural model of the voter, and pushes the expected combinational
//   response (mismatch, ready) and the expected post-edge response (vote,
//   masks, flags, register acknowledge/data) into two queues. A monitor
//   process pops and compares them at fixed points away from the clock edge.
// ----------------------------------------------------------------------------
module tb_tmr_voter_monitor;

  localparam int WIDTH = 32;
  localparam int CW    = 4;
  localparam int TH    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rep_a_i, rep_b_i, rep_c_i;
  logic [31:0] voted_o;
  logic [2:0]  mismatch_o, faulty_o;
  logic        double_fault_o;
  logic        valid_i, we_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic [31:0] rdata_o;

  always #5 clk = ~clk;

  tmr_voter_monitor #(
    .WIDTH(WIDTH), .CNT_WIDTH(CW), .FAULT_THRESH(TH), .REG_OUT(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .rep_a_i(rep_a_i), .rep_b_i(rep_b_i), .rep_c_i(rep_c_i),
    .voted_o(voted_o), .mismatch_o(mismatch_o), .faulty_o(faulty_o),
    .double_fault_o(double_fault_o),
    .valid_i(valid_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .rdata_o(rdata_o)
  );

  typedef struct { logic [2:0] mm; logic rdy; } now_t;
  typedef struct {
    logic [31:0] voted; logic [2:0] faulty; logic df; logic rdy; logic [31:0] rdata;
  } post_t;

  now_t  now_q[$];
  post_t post_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit [2:0] m_faulty, m_sticky;
  bit       m_df, m_ready;
  int       m_streak[3];
  int       m_cnt[3];

  // Register-port master state
  bit          req_pending, req_accepted, req_we;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;

  task automatic start_req(input bit we, input logic [1:0] addr, input logic [31:0] wd);
    req_pending  = 1'b1;
    req_accepted = 1'b0;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  // Drive one cycle and predict its outcome.
  task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input bit do_rst);
    logic [31:0] rep[3];
    logic [31:0] vote;
    logic [31:0] rdata;
    bit [2:0]    mm, hit;
    bit          pair_dis, accept;
    int          ones, lo;
    int          healthy[$];
    now_t        nw;
    post_t       pt;

    @(negedge clk);
    rep_a_i = a; rep_b_i = b; rep_c_i = c;
    rst     = do_rst;
    valid_i = req_pending; we_i = req_we; addr_i = req_addr; wdata_i = req_wdata;
    rep[0] = a; rep[1] = b; rep[2] = c;

    mm = '0; pair_dis = 1'b0; vote = '0;
    if (m_faulty == 3'b000) begin
      for (int j = 0; j < WIDTH; j++) begin
        ones    = int'(a[j]) + int'(b[j]) + int'(c[j]);
        vote[j] = (ones >= 2);
      end
      for (int i = 0; i < 3; i++) mm[i] = (rep[i] != vote);
    end else begin
      for (int i = 0; i < 3; i++) if (!m_faulty[i]) healthy.push_back(i);
      vote = rep[healthy[0]];
      if (rep[healthy[0]] != rep[healthy[1]]) begin
        pair_dis         = 1'b1;
        mm[healthy[0]]   = 1'b1;
        mm[healthy[1]]   = 1'b1;
      end
    end
    nw.mm  = mm;
    nw.rdy = m_ready && !do_rst;
    now_q.push_back(nw);

    if (do_rst) begin
      m_faulty = '0; m_sticky = '0; m_df = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin m_streak[i] = 0; m_cnt[i] = 0; end
      req_accepted = 1'b0;
      pt = '{32'h0, 3'b000, 1'b0, 1'b0, 32'h0};
      post_q.push_back(pt);
      return;
    end

    accept = req_pending && !m_ready;
    rdata  = '0;
    if (accept && !req_we)
      rdata = (req_addr == 2'd0) ? {25'b0, m_df, m_faulty, m_sticky}
                                 : 32'(m_cnt[int'(req_addr) - 1]);

    hit = '0;
    for (int i = 0; i < 3; i++) begin
      m_streak[i] = mm[i] ? m_streak[i] + 1 : 0;
      if (m_streak[i] == TH) hit[i] = 1'b1;
    end
    if (pair_dis) m_df = 1'b1;
    if (hit != 3'b000) begin
      if (m_faulty == 3'b000) begin
        lo = 0;
        for (int i = 2; i >= 0; i--) if (hit[i]) lo = i;
        m_faulty[lo] = 1'b1;
        if ($countones(hit) > 1) m_df = 1'b1;
      end else begin
        m_df = 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) if (mm[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    m_sticky |= mm;

    if (accept && req_we) begin
      if (req_addr == 2'd0) begin
        m_sticky &= ~req_wdata[2:0];
        for (int i = 0; i < 3; i++)
          if (req_wdata[3+i]) begin m_faulty[i] = 1'b0; m_streak[i] = 0; end
        if (req_wdata[6]) m_df = 1'b0;
      end else begin
        m_cnt[int'(req_addr) - 1] = 0;
      end
    end

    // The master keeps valid high through the acknowledge cycle, then drops it.
    if (m_ready && req_accepted) begin
      req_pending  = 1'b0;
      req_accepted = 1'b0;
    end
    if (accept) req_accepted = 1'b1;
    m_ready = accept;

    pt = '{vote, m_faulty, m_df, m_ready, rdata};
    post_q.push_back(pt);
  endtask

  task automatic access(input bit we, input logic [1:0] addr, input logic [31:0] wd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    start_req(we, addr, wd);
    for (int k = 0; k < 4 && req_pending; k++) cycle(a, b, c, 1'b0);
  endtask

  // Monitor
  initial begin
    now_t  nw;
    post_t pt;
    forever begin
      @(negedge clk); #3;
      if (now_q.size() > 0) begin
        nw = now_q.pop_front();
        check("mismatch_o", 32'(mismatch_o), 32'(nw.mm));
        check("ready_o_live", 32'(ready_o), 32'(nw.rdy));
      end
      @(posedge clk); #2;
      if (post_q.size() > 0) begin
        pt = post_q.pop_front();
        check("voted_o", voted_o, pt.voted);
        check("faulty_o", 32'(faulty_o), 32'(pt.faulty));
        check("double_fault_o", 32'(double_fault_o), 32'(pt.df));
        check("ready_o", 32'(ready_o), 32'(pt.rdy));
        if (pt.rdy) check("rdata_o", rdata_o, pt.rdata);
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] r[3];
    logic [31:0] base;
    int          bad;
    bit          hit_bad;

    rst = 1'b1; rep_a_i = '0; rep_b_i = '0; rep_c_i = '0;
    valid_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    req_pending = 1'b0; req_accepted = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    m_faulty = '0; m_sticky = '0; m_df = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin m_streak[i] = 0; m_cnt[i] = 0; end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_voted_o", voted_o, 32'h0);
    check("rst_faulty_o", 32'(faulty_o), 32'h0);
    check("rst_double_fault_o", 32'(double_fault_o), 32'h0);
    check("rst_ready_o", 32'(ready_o), 32'h0);
    check("rst_rdata_o", rdata_o, 32'h0);
    check("rst_mismatch_o", 32'(mismatch_o), 32'h0);

    // All replicas agree.
    repeat (20) cycle(32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000, 1'b0);
    for (int i = 1; i < 4; i++) access(1'b0, 2'(i), 32'h0, 32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000);

    // Single-cycle disagreement of replica 1, then W1C of its sticky bit.
    cycle(32'h0, 32'h1, 32'h0, 1'b0);
    access(1'b0, 2'd2, 32'h0, 32'h0, 32'h0, 32'h0);
    access(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    access(1'b1, 2'd0, 32'h2, 32'h0, 32'h0, 32'h0);
    access(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Replica 2 reaches the threshold, then keeps disagreeing while masked.
    repeat (TH) cycle(32'h0, 32'h0, 32'h80, 1'b0);
    access(1'b0, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) cycle(32'h0, 32'h0, 32'h1, 1'b0);
    access(1'b0, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0);

    // Healthy pair disagrees: lowest healthy replica wins, double fault.
    cycle(32'h5, 32'h6, 32'h0, 1'b0);
    access(1'b0, 2'd0, 32'h0, 32'h5, 32'h5, 32'h0);

    // Counter saturation on a persistently disagreeing pair.
    repeat (20) cycle(32'h1, 32'h0, 32'h0, 1'b0);
    access(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);

    // Counter clear collides with an increment: the clear wins.
    start_req(1'b1, 2'd1, 32'hDEAD_BEEF);
    cycle(32'h1, 32'h0, 32'h0, 1'b0);
    cycle(32'h0, 32'h0, 32'h0, 1'b0);
    access(1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);

    // Clear every status bit, then reset in the middle of an access.
    access(1'b1, 2'd0, 32'h7F, 32'h0, 32'h0, 32'h0);
    access(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle(32'h0, 32'h3, 32'h0, 1'b0);
    start_req(1'b0, 2'd2, 32'h0);
    cycle(32'h0, 32'h0, 32'h0, 1'b1);
    cycle(32'h0, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 4 && req_pending; k++) cycle(32'h0, 32'h0, 32'h0, 1'b0);

    // Randomised phases, each with one preferred misbehaving replica.
    for (int ph = 0; ph < 30; ph++) begin
      bad = $urandom_range(0, 3);
      repeat (50) begin
        base = $urandom;
        for (int i = 0; i < 3; i++) begin
          r[i]    = base;
          hit_bad = (i == bad) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 19) == 0);
          if (hit_bad) r[i] ^= 32'd1 << $urandom_range(0, 31);
        end
        if (!req_pending && $urandom_range(0, 3) == 0)
          start_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    $urandom & (($urandom_range(0, 3) == 0) ? 32'hFF : 32'h07));
        cycle(r[0], r[1], r[2], $urandom_range(0, 299) == 0);
      end
    end

    repeat (3) @(negedge clk);
    check("now_queue_drained", now_q.size(), 32'h0);
    check("post_queue_drained", post_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
